apb_regbank: RTL and testbench
==============================

# apb_regbank

Parametrised APB slave register bank: the next generation of the team's fixed four-register AMBA slave, generalised to NUM_REGS registers of DATA_WIDTH bits, with PSEL decode, byte strobes, configurable wait states, read-only hardware status registers and PSLVERR reporting. It sits between the APB interconnect and the ZigBee datapath. Writable registers drive the datapath through `reg_out` and per-register write pulses. Status registers are sampled from `status_in`.

## Interface
- DATA_WIDTH, 32, register and bus data width; multiple of 8
- ADDR_WIDTH, 4, width of PADDR; PADDR is a word index, not a byte address
- NUM_REGS, 8, number of implemented registers, 1..2**ADDR_WIDTH
- WAIT_STATES, 0, extra ACCESS cycles before PREADY, 0..15
- RO_MASK, 0, NUM_REGS-bit mask; bit i = 1 makes register i read-only status
- PCLK  in  1  clock, rising-edge active
- PRESET  in  1  asynchronous, active-low reset
- PSEL  in  1  slave select
- PENABLE  in  1  APB access phase
- PnR_W  in  1  1 = write, 0 = read
- PADDR  in  ADDR_WIDTH  register index
- PWDATA  in  DATA_WIDTH  write data
- PSTRB  in  DATA_WIDTH/8  byte write strobes
- PREADY  out  1  transfer completes this cycle
- PRDATA  out  DATA_WIDTH  read data; valid only while PREADY=1 and PnR_W=0
- PSLVERR  out  1  error response; valid only while PREADY=1
- status_in  in  NUM_REGS*DATA_WIDTH  hardware status; slice i is read for RO register i
- reg_out  out  NUM_REGS*DATA_WIDTH  current register contents; slice i = register i; RO slices are 0
- wr_pulse  out  NUM_REGS  one-cycle pulse after a successful write to register i

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE -> SETUP when PSEL=1 and PENABLE=0. At this transition, latch PADDR, PnR_W, PWDATA and PSTRB, and clear the wait counter.
- SETUP -> ACCESS when PSEL=1 and PENABLE=1.
- SETUP -> IDLE when PSEL=0.
- ACCESS holds while the wait counter is below WAIT_STATES; the counter increments once per cycle.
- ACCESS -> IDLE after the PREADY cycle. If PSEL=1 and PENABLE=0 in that next cycle, the FSM instead goes straight to SETUP (back-to-back transfer).
- PENABLE=1 seen in IDLE is a protocol violation: ignore it, stay in IDLE, assert no PREADY.
- PSEL dropped in SETUP or ACCESS aborts the transfer: go to IDLE with no write, no pulse and no PREADY.
- Error is flagged when the latched index is >= NUM_REGS, or on a write to a register with its RO_MASK bit set.
- An errored transfer asserts PSLVERR with PREADY, changes no register, drives PRDATA=0 and produces no wr_pulse.
- Write: for each byte b with PSTRB[b]=1, register[idx] byte b <= latched PWDATA byte b. Bytes with a 0 strobe are unchanged.
- A write with PSTRB all zero is legal: PREADY with no error, register unchanged, wr_pulse still asserted.
- Read:
  - RW register: PRDATA = register value.
  - RO register: PRDATA = status_in slice sampled in the PREADY cycle.
  - Out of range: PRDATA = 0 with PSLVERR.
- PRDATA = 0 whenever PREADY=0 or PnR_W=1.
- Reset (PRESET=0, any time including mid-transfer):
  - FSM to IDLE, all registers and wait counter to 0.
  - PREADY=0, PSLVERR=0, PRDATA=0, reg_out=0, wr_pulse=0, immediately and asynchronously.
  - A transfer in flight is lost.

## Timing
- PREADY is decoded from state registers: 1 in the ACCESS cycle where counter == WAIT_STATES, else 0. It is never combinational from bus inputs.
- Transfer length: 2 + WAIT_STATES cycles (SETUP + ACCESS cycles).
- Register update takes effect on the PCLK edge that ends the PREADY cycle. reg_out reflects the new value from the next cycle.
- wr_pulse[i] is high for exactly the one cycle after that edge.
- Read-after-write to the same register in back-to-back transfers returns the new value.
- PWDATA and PADDR changes after SETUP have no effect, because the values are latched.

## Test plan
- Reset, then with WAIT_STATES=0 write 0x35, 0x72, 0x00, 0xAF to registers 0..3 (PSTRB=0xF), then read them back -> each transfer is 2 cycles, PRDATA returns 0x35, 0x72, 0x00, 0xAF, PSLVERR=0, wr_pulse fires once per write.
- Register 1 = 0x11223344; write 0xAABBCCDD with PSTRB=0b0101 -> reads 0x11BB33DD.
- WAIT_STATES=3: a read is 5 cycles, PREADY is high only in the last cycle, and PRDATA=0 in the earlier ACCESS cycles.
- RO_MASK=0x80, status_in slice 7 = 0xDEADBEEF:
  - read register 7 -> 0xDEADBEEF.
  - write register 7 -> PSLVERR=1, no wr_pulse.
  - read index 9 (NUM_REGS=8) -> PSLVERR=1, PRDATA=0.
- Drop PSEL in the second ACCESS cycle of a write with WAIT_STATES=2 -> register unchanged, no PREADY. A following normal write completes.
- Assert PRESET=0 mid-ACCESS after register 2 was set to 0x55 -> outputs go 0 at once. After release, register 2 reads 0 and the next transfer is normal.

Source files
------------

// File: rtl/apb_regbank_if.sv
// APB bus bundle for the register bank: master drives the request, slave returns
// the ready/data/error response.
interface apb_regbank_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    logic                      PSEL;
    logic                      PENABLE;
    logic                      PnR_W;
    logic [ADDR_WIDTH-1:0]     PADDR;
    logic [DATA_WIDTH-1:0]     PWDATA;
    logic [DATA_WIDTH/8-1:0]   PSTRB;
    logic                      PREADY;
    logic [DATA_WIDTH-1:0]     PRDATA;
    logic                      PSLVERR;

    modport master (
        output PSEL, PENABLE, PnR_W, PADDR, PWDATA, PSTRB,
        input  PREADY, PRDATA, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PnR_W, PADDR, PWDATA, PSTRB,
        output PREADY, PRDATA, PSLVERR
    );
endinterface

// File: rtl/apb_regbank.sv
// Parametrised APB slave register bank with byte strobes, wait states, read-only
// status registers and error reporting; drives the ZigBee datapath via reg_out.
module apb_regbank #(
    parameter int                   DATA_WIDTH  = 32,
    parameter int                   ADDR_WIDTH  = 4,
    parameter int                   NUM_REGS    = 8,
    parameter int                   WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0]  RO_MASK     = '0
) (
    input  logic                           PCLK,
    input  logic                           PRESET,
    apb_regbank_if.slave                   bus,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            wr_pulse
);
    localparam int         STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [3:0] WS         = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                  state;
    state_t                  next_state;
    logic [3:0]              wait_cnt;
    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic                    lat_write;
    logic [DATA_WIDTH-1:0]   lat_wdata;
    logic [STRB_WIDTH-1:0]   lat_strb;
    logic [DATA_WIDTH-1:0]   regs [NUM_REGS];

    logic                    ready;
    logic                    capture;
    logic                    cnt_inc;
    logic                    commit;
    logic                    hit;
    logic                    sel_ro;
    logic                    error;
    logic [DATA_WIDTH-1:0]   sel_reg;
    logic [DATA_WIDTH-1:0]   sel_status;

    // Decode the latched index; an index with no matching register leaves hit low.
    always_comb begin
        hit        = 1'b0;
        sel_ro     = 1'b0;
        sel_reg    = '0;
        sel_status = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (lat_addr == ADDR_WIDTH'(i)) begin
                hit        = 1'b1;
                sel_ro     = RO_MASK[i];
                sel_reg    = regs[i];
                sel_status = status_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign error = !hit || (lat_write && sel_ro);
    assign ready = (state == ACCESS) && (wait_cnt == WS);

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            lat_addr  <= '0;
            lat_write <= 1'b0;
            lat_wdata <= '0;
            lat_strb  <= '0;
        end else begin
            state <= next_state;
            if (capture) begin
                wait_cnt  <= '0;
                lat_addr  <= bus.PADDR;
                lat_write <= bus.PnR_W;
                lat_wdata <= bus.PWDATA;
                lat_strb  <= bus.PSTRB;
            end else if (cnt_inc) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end
    end

    // A dropped PSEL anywhere after IDLE abandons the transfer without committing.
    always_comb begin
        next_state = state;
        capture    = 1'b0;
        cnt_inc    = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.PSEL && !bus.PENABLE) begin
                    next_state = SETUP;
                    capture    = 1'b1;
                end
            end
            SETUP: begin
                if (!bus.PSEL)
                    next_state = IDLE;
                else if (bus.PENABLE)
                    next_state = ACCESS;
            end
            ACCESS: begin
                if (!bus.PSEL) begin
                    next_state = IDLE;
                end else if (!ready) begin
                    cnt_inc = 1'b1;
                end else begin
                    next_state = IDLE;
                    commit     = lat_write && !error;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
            wr_pulse <= '0;
        end else begin
            wr_pulse <= '0;
            if (commit) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (lat_addr == ADDR_WIDTH'(i)) begin
                        wr_pulse[i] <= 1'b1;
                        for (int b = 0; b < STRB_WIDTH; b++)
                            if (lat_strb[b])
                                regs[i][b*8 +: 8] <= lat_wdata[b*8 +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        reg_out = '0;
        for (int i = 0; i < NUM_REGS; i++)
            reg_out[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? '0 : regs[i];
    end

    assign bus.PREADY  = ready;
    assign bus.PSLVERR = ready && error;
    assign bus.PRDATA  = (ready && !lat_write && !error) ? (sel_ro ? sel_status : sel_reg) : '0;

endmodule

// File: tb/tb_apb_regbank.sv
// Directed bench for apb_regbank: three instances (0, 3 and 2 wait states) share one
// stimulus bus; a model and scoreboard queue supply every expected response.
module tb_apb_regbank;
    localparam int         NR   = 8;
    localparam logic [7:0] RO   = 8'h80;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        psel    = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite  = 1'b0;
    logic [3:0]  paddr   = '0;
    logic [31:0] pwdata  = '0;
    logic [3:0]  pstrb   = '0;
    int          target  = 0;

    logic [255:0] status;
    logic [255:0] reg_out_a, reg_out_b, reg_out_c;
    logic [7:0]   pulse_a, pulse_b, pulse_c;

    apb_regbank_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus_a ();
    apb_regbank_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus_b ();
    apb_regbank_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus_c ();

    assign bus_a.PSEL = psel && (target == 0);
    assign bus_b.PSEL = psel && (target == 1);
    assign bus_c.PSEL = psel && (target == 2);
    assign bus_a.PENABLE = penable;
    assign bus_b.PENABLE = penable;
    assign bus_c.PENABLE = penable;
    assign bus_a.PnR_W = pwrite;
    assign bus_b.PnR_W = pwrite;
    assign bus_c.PnR_W = pwrite;
    assign bus_a.PADDR = paddr;
    assign bus_b.PADDR = paddr;
    assign bus_c.PADDR = paddr;
    assign bus_a.PWDATA = pwdata;
    assign bus_b.PWDATA = pwdata;
    assign bus_c.PWDATA = pwdata;
    assign bus_a.PSTRB = pstrb;
    assign bus_b.PSTRB = pstrb;
    assign bus_c.PSTRB = pstrb;

    apb_regbank #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_REGS(NR), .WAIT_STATES(0), .RO_MASK(RO)) dut_a (
        .PCLK(clk), .PRESET(rst_n), .bus(bus_a.slave),
        .status_in(status), .reg_out(reg_out_a), .wr_pulse(pulse_a));
    apb_regbank #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_REGS(NR), .WAIT_STATES(3), .RO_MASK(RO)) dut_b (
        .PCLK(clk), .PRESET(rst_n), .bus(bus_b.slave),
        .status_in(status), .reg_out(reg_out_b), .wr_pulse(pulse_b));
    apb_regbank #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_REGS(NR), .WAIT_STATES(2), .RO_MASK(RO)) dut_c (
        .PCLK(clk), .PRESET(rst_n), .bus(bus_c.slave),
        .status_in(status), .reg_out(reg_out_c), .wr_pulse(pulse_c));

    logic         pready_m, pslverr_m;
    logic [31:0]  prdata_m;
    logic [7:0]   pulse_m;
    logic [255:0] reg_out_m;

    // Route the selected instance's response onto one observation point.
    always_comb begin
        pready_m  = bus_a.PREADY;
        pslverr_m = bus_a.PSLVERR;
        prdata_m  = bus_a.PRDATA;
        pulse_m   = pulse_a;
        reg_out_m = reg_out_a;
        if (target == 1) begin
            pready_m  = bus_b.PREADY;
            pslverr_m = bus_b.PSLVERR;
            prdata_m  = bus_b.PRDATA;
            pulse_m   = pulse_b;
            reg_out_m = reg_out_b;
        end else if (target == 2) begin
            pready_m  = bus_c.PREADY;
            pslverr_m = bus_c.PSLVERR;
            prdata_m  = bus_c.PRDATA;
            pulse_m   = pulse_c;
            reg_out_m = reg_out_c;
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        slverr;
        logic [7:0]  pulse;
        int          len;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [3][NR];
    int          total = 0;
    int          bad   = 0;

    task automatic compare(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int ws_of(input int t);
        case (t)
            1:       return 3;
            2:       return 2;
            default: return 0;
        endcase
    endfunction

    task automatic clear_model();
        for (int t = 0; t < 3; t++)
            for (int i = 0; i < NR; i++)
                model[t][i] = '0;
    endtask

    // Pops the expected response for the transfer that just completed.
    task automatic checkOutput(input logic got_ready, input int cycles,
                               input logic [31:0] obs_rdata, input logic obs_err);
        exp_t         e;
        logic [255:0] exp_vec;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("[TB] FAIL scoreboard: observed=empty expected=entry");
            return;
        end
        e = sb.pop_front();
        compare("pready_seen", 256'(got_ready), 256'(1'b1));
        compare("xfer_len", 256'(cycles), 256'(e.len));
        compare("prdata", 256'(obs_rdata), 256'(e.rdata));
        compare("pslverr", 256'(obs_err), 256'(e.slverr));
        compare("wr_pulse", 256'(pulse_m), 256'(e.pulse));
        exp_vec = '0;
        for (int i = 0; i < NR; i++)
            exp_vec[i*32 +: 32] = RO[i] ? 32'h0 : model[target][i];
        compare("reg_out", reg_out_m, exp_vec);
    endtask

    // One full transfer; bus address/data are scrambled after the setup phase.
    task automatic applyStimulus(input int t, input bit wr, input logic [3:0] addr,
                                 input logic [31:0] data, input logic [3:0] strb);
        exp_t        e;
        logic        err;
        logic [31:0] merged;
        logic [2:0]  idx;
        int          cycles;
        logic        got_ready;
        logic [31:0] obs_rdata;
        logic        obs_err;
        idx     = addr[2:0];
        err     = (addr >= 4'd8) || (wr && RO[idx]);
        e.len   = 2 + ws_of(t);
        e.slverr = err;
        e.rdata = '0;
        e.pulse = '0;
        if (!err) begin
            if (wr) begin
                merged = model[t][idx];
                for (int b = 0; b < 4; b++)
                    if (strb[b])
                        merged[b*8 +: 8] = data[b*8 +: 8];
                model[t][idx] = merged;
                e.pulse = 8'(1) << idx;
            end else begin
                e.rdata = RO[idx] ? status[idx*32 +: 32] : model[t][idx];
            end
        end
        sb.push_back(e);
        target = t;

        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr;
        paddr = addr; pwdata = data; pstrb = strb;
        @(posedge clk); #1;
        penable = 1'b1; paddr = addr ^ 4'h1; pwdata = ~data; pstrb = ~strb;

        cycles    = 0;
        got_ready = 1'b0;
        obs_rdata = '0;
        obs_err   = 1'b0;
        while (!got_ready && cycles < 20) begin
            @(negedge clk);
            cycles++;
            if (pready_m) begin
                got_ready = 1'b1;
                obs_rdata = prdata_m;
                obs_err   = pslverr_m;
            end else begin
                compare("prdata_not_ready", 256'(prdata_m), 256'(0));
            end
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        checkOutput(got_ready, cycles, obs_rdata, obs_err);
        @(negedge clk);
        compare("wr_pulse_width", 256'(pulse_m), 256'(0));
    endtask

    // Write to instance C that loses PSEL in its second ACCESS cycle.
    task automatic abortWrite(input logic [3:0] addr, input logic [31:0] data);
        target = 2;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = addr; pwdata = data; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        compare("abort_setup_pready", 256'(pready_m), 256'(0));
        @(posedge clk); #1;
        @(negedge clk);
        compare("abort_acc0_pready", 256'(pready_m), 256'(0));
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            compare("abort_pready", 256'(pready_m), 256'(0));
            compare("abort_pulse", 256'(pulse_m), 256'(0));
        end
    endtask

    // Read on instance B interrupted by reset in its second ACCESS cycle.
    task automatic resetMidAccess(input logic [3:0] addr);
        target = 1;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr; pstrb = 4'h0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        compare("rst_pready", 256'(pready_m), 256'(0));
        compare("rst_pslverr", 256'(pslverr_m), 256'(0));
        compare("rst_prdata", 256'(prdata_m), 256'(0));
        compare("rst_reg_out", reg_out_a | reg_out_b | reg_out_c, 256'(0));
        compare("rst_pulse", 256'(pulse_a | pulse_b | pulse_c), 256'(0));
        clear_model();
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        compare("post_rst_pready", 256'(pready_m), 256'(0));
    endtask

    initial begin
        status = '0;
        for (int i = 0; i < NR; i++)
            status[i*32 +: 32] = 32'h5A5A_0000 | 32'(i);
        status[7*32 +: 32] = 32'hDEAD_BEEF;
        clear_model();

        #12;
        compare("reset_pready", 256'(pready_m), 256'(0));
        compare("reset_pslverr", 256'(pslverr_m), 256'(0));
        compare("reset_prdata", 256'(prdata_m), 256'(0));
        compare("reset_reg_out", reg_out_a | reg_out_b | reg_out_c, 256'(0));
        compare("reset_pulse", 256'(pulse_a | pulse_b | pulse_c), 256'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        $display("[TB] reset released");

        applyStimulus(0, 1'b1, 4'd0, 32'h35, 4'hF);
        applyStimulus(0, 1'b1, 4'd1, 32'h72, 4'hF);
        applyStimulus(0, 1'b1, 4'd2, 32'h00, 4'hF);
        applyStimulus(0, 1'b1, 4'd3, 32'hAF, 4'hF);
        for (int i = 0; i < 4; i++)
            applyStimulus(0, 1'b0, 4'(i), 32'h0, 4'h0);

        applyStimulus(0, 1'b1, 4'd1, 32'h1122_3344, 4'hF);
        applyStimulus(0, 1'b1, 4'd1, 32'hAABB_CCDD, 4'b0101);
        applyStimulus(0, 1'b0, 4'd1, 32'h0, 4'h0);

        applyStimulus(0, 1'b1, 4'd0, 32'hFFFF_FFFF, 4'h0);
        applyStimulus(0, 1'b0, 4'd0, 32'h0, 4'h0);

        applyStimulus(0, 1'b0, 4'd7, 32'h0, 4'h0);
        applyStimulus(0, 1'b1, 4'd7, 32'h1234_5678, 4'hF);
        applyStimulus(0, 1'b0, 4'd7, 32'h0, 4'h0);
        applyStimulus(0, 1'b0, 4'd9, 32'h0, 4'h0);
        applyStimulus(0, 1'b1, 4'd12, 32'hCAFE_F00D, 4'hF);

        applyStimulus(1, 1'b1, 4'd5, 32'h0F0F_A5A5, 4'hF);
        applyStimulus(1, 1'b0, 4'd5, 32'h0, 4'h0);

        applyStimulus(2, 1'b1, 4'd4, 32'h0BAD_F00D, 4'hF);
        abortWrite(4'd4, 32'hFFFF_FFFF);
        applyStimulus(2, 1'b0, 4'd4, 32'h0, 4'h0);
        applyStimulus(2, 1'b1, 4'd4, 32'h1234_5678, 4'hF);
        applyStimulus(2, 1'b0, 4'd4, 32'h0, 4'h0);

        applyStimulus(1, 1'b1, 4'd2, 32'h55, 4'hF);
        resetMidAccess(4'd2);
        applyStimulus(1, 1'b0, 4'd2, 32'h0, 4'h0);
        applyStimulus(1, 1'b1, 4'd2, 32'h6666_7777, 4'b1100);
        applyStimulus(1, 1'b0, 4'd2, 32'h0, 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
